uart_tx_mmio: RTL and testbench



---
 rtl/uart_mmio_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 55 +++++
 rtl/uart_tx_mmio.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_mmio_pkg.sv
// Shared register offsets, STATUS bit positions and transmitter state encoding
// for the memory-mapped UART transmitter.
package uart_mmio_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] CTRL_OFS   = 4'h8;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through dout; push when full and pop when
// empty are ignored, so the producer owns overflow policy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// CPU-bus mapped 8N1 UART transmitter: combinational register reads, one-cycle store capture,
// frames start one cycle after a byte is queued; stores to a full FIFO are dropped and flagged.
module uart_tx_mmio
  import uart_mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic        IO_Sel,
  output logic [31:0] IO_RdData,
  output logic        uart_tx
);

  localparam int          CW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  logic [3:0]  ofs;
  logic        wr_en;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic [CW:0] fifo_count;
  logic        overflow;
  logic        tx_en;
  logic [31:0] status_word;
  logic        unused_wrdata;

  tx_state_t   state, state_n;
  logic [15:0] baud_cnt, baud_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shreg, shreg_n;
  logic        tx_n;
  logic        bit_end;

  assign IO_Sel        = (Mem_WrAddr[31:4] == BASE_ADDR[31:4]);
  assign ofs           = Mem_WrAddr[3:0];
  assign wr_en         = MemWrite & IO_Sel;
  assign fifo_push     = wr_en && (ofs == TXDATA_OFS) && !fifo_full;
  assign unused_wrdata = ^Mem_WrData[31:8];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (Mem_WrData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    status_word                     = '0;
    status_word[ST_FULL]            = fifo_full;
    status_word[ST_EMPTY]           = fifo_empty;
    status_word[ST_BUSY]            = (state != IDLE);
    status_word[ST_OVF]             = overflow;
    status_word[ST_CNT_LSB +: 8]    = 8'(fifo_count);
  end

  always_comb begin
    IO_RdData = '0;
    if (IO_Sel) begin
      case (ofs)
        STATUS_OFS: IO_RdData = status_word;
        CTRL_OFS:   IO_RdData = {31'b0, tx_en};
        default:    IO_RdData = '0;
      endcase
    end
  end

  // Full is judged on pre-edge state, so a drop can coincide with a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      tx_en    <= 1'b1;
    end else begin
      if (wr_en && (ofs == TXDATA_OFS) && fifo_full) begin
        overflow <= 1'b1;
      end else if (wr_en && (ofs == STATUS_OFS) && Mem_WrData[ST_OVF]) begin
        overflow <= 1'b0;
      end
      if (wr_en && (ofs == CTRL_OFS)) begin
        tx_en <= Mem_WrData[0];
      end
    end
  end

  assign bit_end = (baud_cnt == BAUD_MAX);

  always_comb begin
    state_n   = state;
    baud_n    = bit_end ? 16'd0 : baud_cnt + 16'd1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    fifo_pop  = 1'b0;
    tx_n      = 1'b1;
    case (state)
      IDLE: begin
        baud_n = '0;
        if (!fifo_empty && tx_en) begin
          fifo_pop = 1'b1;
          shreg_n  = fifo_dout;
          state_n  = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      STOP: begin
        // Refill straight from the FIFO so back-to-back frames have no idle gap.
        if (bit_end) begin
          if (!fifo_empty && tx_en) begin
            fifo_pop = 1'b1;
            shreg_n  = fifo_dout;
            state_n  = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[bit_idx_n];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      uart_tx  <= tx_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed and randomized bench for uart_tx_mmio: a line monitor decodes 8N1 frames and
// records their start cycle; expected bytes and start times follow from frame arithmetic.
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          FRAME = 10 * CPB;
  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam logic [31:0] A_TX  = BASE + 32'h0;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_CT  = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] Mem_WrAddr = '0;
  logic [31:0] Mem_WrData = '0;
  logic        IO_Sel;
  logic [31:0] IO_RdData;
  logic        uart_tx;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         rx_t[$];

  logic       mon_s [0:39];
  int         mon_n = 0;
  int         mon_t0 = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .Mem_WrAddr (Mem_WrAddr),
    .Mem_WrData (Mem_WrData),
    .IO_Sel     (IO_Sel),
    .IO_RdData  (IO_RdData),
    .uart_tx    (uart_tx)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Line monitor: 40 samples per frame, one per cycle, each bit must be constant for CPB samples.
  initial begin
    logic       ok;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_n = 0;
      end else if (mon_n == 0) begin
        if (uart_tx === 1'b0) begin
          mon_s[0] = 1'b0;
          mon_n    = 1;
          mon_t0   = cyc;
        end
      end else begin
        mon_s[mon_n] = uart_tx;
        mon_n++;
        if (mon_n == FRAME) begin
          ok = 1'b1;
          for (int k = 0; k < 10; k++)
            for (int j = 0; j < CPB; j++)
              if (mon_s[k*CPB + j] !== mon_s[k*CPB]) ok = 1'b0;
          if (mon_s[9*CPB] !== 1'b1) ok = 1'b0;
          for (int k = 0; k < 8; k++) b[k] = mon_s[(k+1)*CPB];
          check("frame_shape", 32'(ok), 32'd1);
          rx_q.push_back(b);
          rx_t.push_back(mon_t0);
          mon_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    step();
    MemWrite   = 1'b0;
    Mem_WrAddr = '0;
  endtask

  task automatic chk_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    MemWrite   = 1'b0;
    Mem_WrAddr = a;
    #1;
    check(tag, IO_RdData, exp);
    Mem_WrAddr = '0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) step();
    check(tag, 32'(rx_q.size()), 32'(n));
  endtask

  // Frame i of a burst whose first pop lands at cycle t0 must start at t0 + i*FRAME.
  task automatic check_stream(input string tag, input int t0);
    check({tag, "_cnt"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < rx_q.size()) begin
        check({tag, "_byte"}, {24'b0, rx_q[i]}, {24'b0, exp_q[i]});
        check({tag, "_start"}, 32'(rx_t[i]), 32'(t0 + FRAME*i));
      end
    end
    rx_q.delete();
    rx_t.delete();
    exp_q.delete();
  endtask

  initial begin
    int          t;
    int          n;
    logic [7:0]  b;
    logic [31:0] d;

    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("reset_line", 32'(uart_tx), 32'd1);
    chk_reg("reset_status", A_ST, 32'h0000_0002);
    chk_reg("reset_ctrl", A_CT, 32'h0000_0001);

    // Single frame, pop and start bit one cycle after the store.
    exp_q.push_back(8'h55);
    wr(A_TX, 32'h55);
    t = cyc;
    chk_reg("t1_cnt1", A_ST, 32'h0000_0100);
    step();
    check("t1_start_edge", 32'(uart_tx), 32'd0);
    chk_reg("t1_busy", A_ST, 32'h0000_0006);
    wait_rx("t1_rx", 1, FRAME + 20);
    check_stream("t1", t + 1);
    step();
    chk_reg("t1_after", A_ST, 32'h0000_0002);
    check("t1_line_idle", 32'(uart_tx), 32'd1);

    // Overfill with transmit disabled, clear overflow, then drain.
    wr(A_CT, 32'h0);
    for (int i = 0; i < 9; i++) wr(A_TX, 32'(i));
    chk_reg("t2_full_ovf", A_ST, 32'h0000_0809);
    check("t2_line_held", 32'(uart_tx), 32'd1);
    wr(A_ST, 32'h8);
    chk_reg("t2_w1c", A_ST, 32'h0000_0801);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    wr(A_CT, 32'h1);
    t = cyc;
    wait_rx("t2_rx", 8, 8*FRAME + 20);
    check_stream("t2", t + 1);
    repeat (FRAME) step();
    check("t2_no_ninth", 32'(rx_q.size()), 32'd0);
    chk_reg("t2_after", A_ST, 32'h0000_0002);

    // Store to a full FIFO on the very edge that STOP pops.
    wr(A_CT, 32'h0);
    for (int i = 0; i < 8; i++) begin
      wr(A_TX, 32'h0A0 + 32'(i));
      exp_q.push_back(8'hA0 + 8'(i));
    end
    wr(A_CT, 32'h1);
    t = cyc;
    step();
    wr(A_TX, 32'hEE);
    exp_q.push_back(8'hEE);
    chk_reg("t3_refull", A_ST, 32'h0000_0805);
    while (cyc < t + FRAME) step();
    wr(A_TX, 32'hFF);
    chk_reg("t3_drop", A_ST, 32'h0000_070C);
    wait_rx("t3_rx", 9, 9*FRAME + 20);
    check_stream("t3", t + 1);
    wr(A_ST, 32'h8);
    chk_reg("t3_after", A_ST, 32'h0000_0002);

    // Disable mid-frame with two bytes queued.
    wr(A_TX, 32'hB0);
    t = cyc;
    wr(A_TX, 32'hB1);
    wr(A_TX, 32'hB2);
    exp_q.push_back(8'hB0);
    repeat (10) step();
    wr(A_CT, 32'h0);
    wait_rx("t4_rx", 1, FRAME + 10);
    check_stream("t4", t + 1);
    repeat (FRAME) step();
    check("t4_line", 32'(uart_tx), 32'd1);
    chk_reg("t4_status", A_ST, 32'h0000_0200);
    check("t4_no_more", 32'(rx_q.size()), 32'd0);

    // Reset while the DATA bits are on the line.
    wr(A_CT, 32'h1);
    repeat (12) step();
    chk_reg("t5_pre", A_ST, 32'h0000_0104);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t5_line", 32'(uart_tx), 32'd1);
    chk_reg("t5_status", A_ST, 32'h0000_0002);
    chk_reg("t5_ctrl", A_CT, 32'h0000_0001);
    repeat (FRAME + 10) step();
    check("t5_abandoned", 32'(rx_q.size()), 32'd0);

    // Address decode boundaries.
    MemWrite   = 1'b1;
    Mem_WrAddr = BASE + 32'h10;
    Mem_WrData = 32'h5A;
    #1;
    check("t6_sel_out", 32'(IO_Sel), 32'd0);
    step();
    MemWrite = 1'b0;
    chk_reg("t6_no_push", A_ST, 32'h0000_0002);
    Mem_WrAddr = BASE + 32'hC;
    #1;
    check("t6_sel_c", 32'(IO_Sel), 32'd1);
    check("t6_rd_c", IO_RdData, 32'h0);
    chk_reg("t6_rd_tx", A_TX, 32'h0);
    chk_reg("t6_rd_odd", BASE + 32'h5, 32'h0);
    step();
    wr(BASE + 32'h9, 32'h0);
    wr(BASE + 32'h18, 32'h0);
    chk_reg("t6_ctrl_kept", A_CT, 32'h0000_0001);

    // Randomized bursts of back-to-back stores.
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) step();
      n = int'($urandom_range(1, 8));
      t = 0;
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom_range(0, 255));
        exp_q.push_back(b);
        wr(A_TX, {24'b0, b});
        if (i == 0) t = cyc;
      end
      d = (n == 1) ? 32'h0000_0100 : ((32'(n - 1) << 8) | 32'h4);
      chk_reg("rnd_status", A_ST, d);
      wait_rx("rnd_rx", n, n*FRAME + 20);
      check_stream("rnd", t + 1);
      step();
      chk_reg("rnd_after", A_ST, 32'h0000_0002);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
